pifo_calendar_param: RTL
========================

# pifo_calendar_param

Parametrised shift-register PIFO calendar: keeps up to DEPTH (rank, buffer address) entries sorted by ascending rank and always presents the minimum-rank entry at the head. It sits between the rank-computation stage and the output-queue buffer manager. It replaces the fixed-size root calendar and adds:
- ready/valid handshakes with single-cycle simultaneous insert and pop
- FIFO order among equal ranks
- a CPU flush
- a CPU read port on the datapath clock

## Interface
Parameters:
- DEPTH, 64, number of calendar cells (≥2)
- RANK_WIDTH, 19, rank field width
- ADDR_WIDTH, 12, buffer address width
- COUNT_WIDTH, $clog2(DEPTH+1), width of occupancy count
- INDEX_WIDTH, $clog2(DEPTH), width of CPU read index

Ports:
- clk  in  1  single clock for all logic
- rstn  in  1  reset, asynchronous, active-low
- s_insert_valid  in  1  insert request
- s_insert_ready  out  1  = ~m_full & ~cpu_flush
- s_insert_rank  in  RANK_WIDTH  rank of new entry
- s_insert_addr  in  ADDR_WIDTH  buffer address of new entry
- m_pop_valid  out  1  = ~m_empty & ~cpu_flush
- m_pop_ready  in  1  pop request
- m_pop_rank  out  RANK_WIDTH  head rank (cell 0)
- m_pop_addr  out  ADDR_WIDTH  head buffer address (cell 0)
- m_count  out  COUNT_WIDTH  number of valid cells
- m_full  out  1  m_count == DEPTH
- m_empty  out  1  m_count == 0
- cpu_flush  in  1  invalidate all cells
- cpu_rd_valid  in  1  read request
- cpu_rd_index  in  INDEX_WIDTH  cell index to read
- cpu_rd_result_valid  out  1  read response strobe
- cpu_rd_result  out  1+RANK_WIDTH+ADDR_WIDTH  {valid, rank, addr} of the cell

## Operation
Entry layout: {valid, rank, addr}.
- Invariant: valid cells are contiguous from cell 0, ranks non-decreasing toward the tail.
- Insert fire = s_insert_valid & s_insert_ready. Pop fire = m_pop_valid & m_pop_ready.

Per-cell compare: gt[i] = ~cell[i].valid | (cell[i].rank > s_insert_rank).
- Strict greater-than, so a new entry lands behind equal ranks (FIFO among ties).
- Boundary values: gt[-1] = 0; gt[DEPTH] = 1.

Next state of cell i:
- Insert only:
  - gt[i] & ~gt[i-1] → new entry
  - gt[i-1] → cell[i-1] (shift toward tail)
  - else hold
- Pop only: cell[i+1]; the last cell becomes invalid.
- Insert + pop (gt[0] forced to 0):
  - ~gt[i+1] → cell[i+1]
  - gt[i+1] & ~gt[i] → new entry
  - else hold
  - The pop always returns the head as registered at cycle start, even if the new rank is smaller.
- cpu_flush: all cells invalid and count 0 next cycle. Concurrent insert/pop cannot fire because ready/valid are gated.

Occupancy count: +1 on insert-only, −1 on pop-only, unchanged on both or neither. It cannot wrap because the handshakes gate it.

CPU read:
- The response samples cell[cpu_rd_index] as it is before any same-cycle update.
- cpu_rd_index ≥ DEPTH returns all-zero with valid asserted.

## Timing
- Head outputs are combinational from the cell 0 register (zero latency). An insert into an empty calendar is visible at the head 1 cycle after fire.
- m_count, m_full, m_empty are registered and update 1 cycle after fire.
- CPU read latency is 1 cycle. cpu_rd_result_valid is a 1-cycle pulse per request; back-to-back requests are allowed.
- Reset values (asynchronous, while rstn low):
  - all cells invalid
  - m_count 0, m_empty 1, m_full 0
  - s_insert_ready 1, m_pop_valid 0
  - cpu_rd_result_valid 0, cpu_rd_result 0
- Reset mid-operation discards all entries; no partial shift survives.
- When full, an insert is refused even with a concurrent pop; the insert may fire on the following cycle.
- A pop request while empty has no effect.

## Structure
- Package pifo_pkg holds:
  - the entry typedef {valid, rank, addr}
  - default widths
  - a rank_gt function implementing the invalid-or-greater compare
- Sub-module pifo_calendar_cell, one per index, instantiated by a generate loop.
  - Inputs: own, head-side and tail-side entries; gt[i-1], gt[i+1]; insert, pop and flush controls; new entry.
  - Outputs: registered entry and gt[i].
- Top level holds:
  - the count register
  - the handshake logic
  - the CPU read mux and its register

## Test plan
- Reset, then insert ranks 5, 3, 9 at addrs 1, 2, 3 → head shows rank 3/addr 2, count 3; pops return addrs 2, 1, 3, then m_empty=1.
- Insert rank 7 three times (addrs 10, 11, 12) → pops return addrs 10, 11, 12 (tie FIFO).
- Holding {5, 8}, same-cycle pop + insert of rank 6 → pop returns rank 5, count stays 2, head becomes rank 6, then rank 8.
- Fill DEPTH entries → m_full=1, s_insert_ready=0. An insert with a concurrent pop is refused. The next cycle's insert is accepted.
- cpu_rd_index 1 after inserting ranks 4, 2 → one cycle later cpu_rd_result = {1, 4, addr}. Index DEPTH → all-zero result with valid.
- cpu_flush with insert_valid and pop_ready high → no fire; the next cycle count is 0 and the head is invalid. Asserting rstn low mid-stream → outputs at reset values immediately.

Source files
------------

// File: rtl/pifo_pkg.sv
// Shared types and helpers for the shift-register PIFO calendar.
package pifo_pkg;

  localparam int DEF_DEPTH      = 64;
  localparam int DEF_RANK_WIDTH = 19;
  localparam int DEF_ADDR_WIDTH = 12;
  localparam int MAX_RANK_WIDTH = 64;

  typedef struct packed {
    logic                      valid;
    logic [DEF_RANK_WIDTH-1:0] rank;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } pifo_entry_t;

  // Strict compare: equal ranks are not "greater", so ties keep arrival order.
  function automatic logic rank_gt(input logic valid,
                                   input logic [MAX_RANK_WIDTH-1:0] cell_rank,
                                   input logic [MAX_RANK_WIDTH-1:0] new_rank);
    return ~valid | (cell_rank > new_rank);
  endfunction

endpackage

// File: rtl/pifo_calendar_cell.sv
// One calendar cell: holds an entry and picks its next value from neighbours or the new entry.
module pifo_calendar_cell
  import pifo_pkg::*;
#(
  parameter int RANK_WIDTH = DEF_RANK_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter bit IS_HEAD    = 1'b0,
  localparam int EW        = 1 + RANK_WIDTH + ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [EW-1:0] prev_entry,
  input  logic [EW-1:0] next_entry,
  input  logic          gt_prev,
  input  logic          gt_next,
  input  logic          ins,
  input  logic          pop,
  input  logic          flush,
  input  logic [EW-1:0] new_entry,
  output logic [EW-1:0] entry,
  output logic          gt
);

  logic [EW-1:0]         nxt;
  logic                  gt_self;
  logic [RANK_WIDTH-1:0] own_rank;
  logic [RANK_WIDTH-1:0] new_rank;

  assign own_rank = entry[EW-2 -: RANK_WIDTH];
  assign new_rank = new_entry[EW-2 -: RANK_WIDTH];
  assign gt = rank_gt(entry[EW-1], MAX_RANK_WIDTH'(own_rank), MAX_RANK_WIDTH'(new_rank));

  // During insert+pop the head always takes over from cell 1 or the new entry.
  assign gt_self = IS_HEAD ? 1'b0 : gt;

  always_comb begin
    nxt = entry;
    if (ins && pop) begin
      if (!gt_next)     nxt = next_entry;
      else if (!gt_self) nxt = new_entry;
    end else if (ins) begin
      if (gt_prev)  nxt = prev_entry;
      else if (gt)  nxt = new_entry;
    end else if (pop) begin
      nxt = next_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      entry <= '0;
    else if (flush) entry <= '0;
    else            entry <= nxt;
  end

endmodule

// File: rtl/pifo_calendar_param.sv
// Parametrised PIFO calendar: sorted shift-register cells, handshakes, occupancy and CPU read port.
module pifo_calendar_param
  import pifo_pkg::*;
#(
  parameter int DEPTH       = DEF_DEPTH,
  parameter int RANK_WIDTH  = DEF_RANK_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1),
  parameter int INDEX_WIDTH = $clog2(DEPTH),
  localparam int EW         = 1 + RANK_WIDTH + ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   s_insert_valid,
  output logic                   s_insert_ready,
  input  logic [RANK_WIDTH-1:0]  s_insert_rank,
  input  logic [ADDR_WIDTH-1:0]  s_insert_addr,
  output logic                   m_pop_valid,
  input  logic                   m_pop_ready,
  output logic [RANK_WIDTH-1:0]  m_pop_rank,
  output logic [ADDR_WIDTH-1:0]  m_pop_addr,
  output logic [COUNT_WIDTH-1:0] m_count,
  output logic                   m_full,
  output logic                   m_empty,
  input  logic                   cpu_flush,
  input  logic                   cpu_rd_valid,
  input  logic [INDEX_WIDTH-1:0] cpu_rd_index,
  output logic                   cpu_rd_result_valid,
  output logic [EW-1:0]          cpu_rd_result
);

  // Handshake: a transfer happens when valid and ready are both high in the same cycle;
  // flush drops both ready and valid so nothing transfers in a flush cycle.
  logic          ins_fire;
  logic          pop_fire;
  logic [EW-1:0] new_entry;
  logic [EW-1:0] cell_e [DEPTH];
  logic          gt_v   [DEPTH];
  logic [EW-1:0] rd_sel;

  assign m_full         = (m_count == COUNT_WIDTH'(DEPTH));
  assign m_empty        = (m_count == '0);
  assign s_insert_ready = ~m_full & ~cpu_flush;
  assign m_pop_valid    = ~m_empty & ~cpu_flush;
  assign ins_fire       = s_insert_valid & s_insert_ready;
  assign pop_fire       = m_pop_valid & m_pop_ready;
  assign new_entry      = {1'b1, s_insert_rank, s_insert_addr};

  assign m_pop_rank = cell_e[0][EW-2 -: RANK_WIDTH];
  assign m_pop_addr = cell_e[0][ADDR_WIDTH-1:0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [EW-1:0] prev_e;
    logic [EW-1:0] next_e;
    logic          gp;
    logic          gn;

    if (i == 0) begin : g_first
      assign prev_e = '0;
      assign gp     = 1'b0;
    end else begin : g_inner_head
      assign prev_e = cell_e[i-1];
      assign gp     = gt_v[i-1];
    end

    // Beyond the tail is an always-greater, always-empty slot.
    if (i == DEPTH - 1) begin : g_last
      assign next_e = '0;
      assign gn     = 1'b1;
    end else begin : g_inner_tail
      assign next_e = cell_e[i+1];
      assign gn     = gt_v[i+1];
    end

    pifo_calendar_cell #(
      .RANK_WIDTH (RANK_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .IS_HEAD    (i == 0)
    ) u_cell (
      .clk        (clk),
      .rstn       (rstn),
      .prev_entry (prev_e),
      .next_entry (next_e),
      .gt_prev    (gp),
      .gt_next    (gn),
      .ins        (ins_fire),
      .pop        (pop_fire),
      .flush      (cpu_flush),
      .new_entry  (new_entry),
      .entry      (cell_e[i]),
      .gt         (gt_v[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      m_count <= '0;
    else if (cpu_flush)             m_count <= '0;
    else if (ins_fire && !pop_fire) m_count <= m_count + COUNT_WIDTH'(1);
    else if (pop_fire && !ins_fire) m_count <= m_count - COUNT_WIDTH'(1);
  end

  // Indices past the last cell match nothing and read back as zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (cpu_rd_index == INDEX_WIDTH'(k)) rd_sel = cell_e[k];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpu_rd_result_valid <= 1'b0;
      cpu_rd_result       <= '0;
    end else begin
      cpu_rd_result_valid <= cpu_rd_valid;
      if (cpu_rd_valid) cpu_rd_result <= rd_sel;
    end
  end

endmodule
